// File: rtl/dmem_pkg.sv
// dmem_pkg: shared states, owner tags and store/load encoding for the data-memory arbiter
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic       OWN_CPU  = 1'b0;
    localparam logic       OWN_DBG  = 1'b1;
    localparam logic [3:0] DWE_LOAD = 4'b0000;

endpackage

// File: rtl/dmem_arbiter_lat_counter.sv
// lat_counter: 4-bit load/decrement counter that flags when the read latency has elapsed
module lat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    input  logic [3:0] din,
    output logic       zero
);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        cnt <= rst ? 4'd0 : load ? din : (dec && !zero) ? cnt - 4'd1 : cnt;
    end

    assign zero = cnt == 4'd0;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between the CPU MEM stage and a debug requester
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_dwe,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    input  logic [3:0]  dbg_dwe,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_done,
    output logic [31:0] dbg_rdata,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_dwe,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0]  LAT_INIT = 4'(MEM_LAT - 1);
    localparam logic [3:0]  SMAX     = 4'(STARVE_MAX);
    localparam logic [31:0] ALIGN    = 32'hFFFF_FFFC;

    state_t      state;
    logic        own;
    logic [3:0]  starve;
    logic [3:0]  req_dwe;
    logic        zero;
    logic        dbg_win;
    logic        finish;
    logic [31:0] result;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic [3:0]  win_dwe;

    // Debug takes the port when the CPU is quiet or has been favoured STARVE_MAX times in a row
    assign dbg_win   = dbg_req && (!cpu_req || starve == SMAX);
    assign win_addr  = dbg_win ? dbg_addr : cpu_addr;
    assign win_dwe   = dbg_win ? dbg_dwe : cpu_dwe;
    assign win_wdata = dbg_win ? dbg_wdata : cpu_wdata;
    assign finish    = (state == ISSUE && req_dwe != DWE_LOAD) || (state == WAIT && zero);
    assign result    = state == WAIT ? mem_rdata : 32'd0;
    assign cpu_stall = cpu_req && !cpu_done;

    lat_counter u_lat (
        .clk  (clk),
        .rst  (rst),
        .load (state == ISSUE && req_dwe == DWE_LOAD),
        .dec  (state == WAIT),
        .din  (LAT_INIT),
        .zero (zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            own       <= OWN_CPU;
            starve    <= 4'd0;
            req_dwe   <= DWE_LOAD;
            mem_en    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_dwe   <= DWE_LOAD;
            mem_wdata <= 32'd0;
            cpu_done  <= 1'b0;
            dbg_done  <= 1'b0;
            cpu_rdata <= 32'd0;
            dbg_rdata <= 32'd0;
        end else begin
            mem_en   <= 1'b0;
            mem_dwe  <= DWE_LOAD;
            cpu_done <= 1'b0;
            dbg_done <= 1'b0;
            case (state)
                IDLE: if (cpu_req || dbg_req) begin
                    state     <= ISSUE;
                    own       <= dbg_win ? OWN_DBG : OWN_CPU;
                    req_dwe   <= win_dwe;
                    mem_en    <= 1'b1;
                    mem_addr  <= win_addr & ALIGN;
                    mem_dwe   <= win_dwe;
                    mem_wdata <= win_wdata;
                    starve    <= dbg_win ? 4'd0 : (dbg_req && starve != SMAX) ? starve + 4'd1 : starve;
                end
                ISSUE:   state <= req_dwe == DWE_LOAD ? WAIT : DONE;
                WAIT:    state <= zero ? DONE : WAIT;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (finish) begin
                cpu_done <= own == OWN_CPU;
                dbg_done <= own == OWN_DBG;
                if (own == OWN_DBG) dbg_rdata <= result;
                else cpu_rdata <= result;
            end
        end
    end

endmodule
